// File: rtl/sys_defs.sv
// Shared fetch/dispatch definitions: buffer depth default, WFI encoding,
// and the packet handed from fetch to decode/dispatch.
`ifndef SYS_DEFS_SV
`define SYS_DEFS_SV
`define FB_DEPTH 4
`define WFI 32'h10500073
`endif

package sys_defs;
  localparam int unsigned FB_DEPTH_DEF = `FB_DEPTH;
  localparam logic [31:0] WFI_INST     = `WFI;

  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
    logic [31:0] PC;
    logic [31:0] NPC;
  } FETCH_DISPATCH_PACKET;
endpackage

// File: rtl/fetch_fifo.sv
// Circular fetch buffer: push at tail, pop at head, synchronous flush.
// The head entry is presented combinationally; an empty buffer shows all-zero.
module fetch_fifo
  import sys_defs::*;
#(
  parameter int unsigned DEPTH = FB_DEPTH_DEF
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         i_push,
  input  logic                         i_pop,
  input  logic                         i_flush,
  input  FETCH_DISPATCH_PACKET         i_data,
  output FETCH_DISPATCH_PACKET         o_data,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  FETCH_DISPATCH_PACKET r_mem [DEPTH];
  logic [PW-1:0] r_head, r_tail;
  logic [CW-1:0] r_count;

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_tail <= r_tail + PW'(1);
      if (i_pop)  r_head <= r_head + PW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; contents are don't-care while not counted, so no reset.
  always_ff @(posedge clock) begin
    if (i_push && !i_flush) r_mem[r_tail] <= i_data;
  end

  assign o_data  = (r_count != '0) ? r_mem[r_head] : '0;
  assign o_count = r_count;
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC sequencing, icache request, WFI halt, and the
// fetch buffer feeding decode/dispatch with one cycle of latency.
module fetch_stage
  import sys_defs::*;
#(
  parameter int unsigned FB_DEPTH = FB_DEPTH_DEF,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                            clock,
  input  logic                            reset,
  output logic                            icache_req,
  output logic [31:0]                     icache_addr,
  input  logic                            icache_hit,
  input  logic [63:0]                     icache_data,
  input  logic                            redirect_valid,
  input  logic [31:0]                     redirect_pc,
  input  logic                            dispatch_ready,
  output FETCH_DISPATCH_PACKET            fetch_packet,
  output logic [$clog2(FB_DEPTH+1)-1:0]   fb_count,
  output logic                            fetch_halted
);
  localparam int unsigned CW = $clog2(FB_DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(FB_DEPTH);

  logic [31:0]          r_pc;
  logic                 r_halted;
  logic                 w_pop, w_push;
  logic [31:0]          w_inst;
  FETCH_DISPATCH_PACKET w_entry;

  // Redirect blocks both ends of the buffer for its cycle.
  assign w_pop      = (fb_count != '0) && dispatch_ready && !redirect_valid;
  assign icache_req = !reset && !redirect_valid && !r_halted &&
                      ((fb_count < FULL) || w_pop);
  assign w_push     = icache_req && icache_hit;

  assign icache_addr = {r_pc[31:3], 3'b000};
  assign w_inst      = r_pc[2] ? icache_data[63:32] : icache_data[31:0];
  assign w_entry     = '{valid: 1'b1, inst: w_inst, PC: r_pc, NPC: r_pc + 32'd4};

  // PC and halt state: redirect wins, otherwise advance on every accepted push.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pc     <= RESET_PC;
      r_halted <= 1'b0;
    end else if (redirect_valid) begin
      r_pc     <= {redirect_pc[31:2], 2'b00};
      r_halted <= 1'b0;
    end else if (w_push) begin
      r_pc <= r_pc + 32'd4;
      if (w_inst == WFI_INST) r_halted <= 1'b1;
    end
  end

  assign fetch_halted = r_halted;

  fetch_fifo #(.DEPTH(FB_DEPTH)) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .i_data  (w_entry),
    .o_data  (fetch_packet),
    .o_count (fb_count)
  );
endmodule
